// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx                                                      |
// | Description : UART transmit serializer, LSB first, 7/8 data bits, one stop |
// |               bit. Optional parity bit is enabled by UART_TX_PARITY_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] data_in,
    input  logic       data_length,
`ifdef UART_TX_PARITY_EN
    input  logic       parity_odd,
`endif
    input  logic       tx_start,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(CLKS_PER_BIT - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_len;
    logic             r_tx;
    logic             r_busy;
    logic             r_tx_done;
`ifdef UART_TX_PARITY_EN
    logic             r_parity;
    logic             w_parity;

    // Parity is resolved at acceptance so later data_in changes cannot affect it.
    assign w_parity = (data_length ? ^data_in : ^data_in[6:0]) ^ parity_odd;
`endif

    logic       w_term;
    logic [2:0] w_last_idx;

    assign w_term     = (r_cnt == c_last_cnt);
    assign w_last_idx = r_len ? 3'd7 : 3'd6;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_len     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_tx  <= 1'b1;
                    if (tx_start) begin
                        r_shift   <= data_in;
                        r_len     <= data_length;
                        r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= w_parity;
`endif
                        r_busy    <= 1'b1;
                        r_tx      <= 1'b0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_term) begin
                        r_cnt   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_term) begin
                        r_cnt <= '0;
                        if (r_bit_idx == w_last_idx) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            // Shift right so the next bit is always at position 1 before the shift.
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_term) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_term) begin
                        r_cnt     <= '0;
                        r_tx_done <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign tx      = r_tx;
    assign busy    = r_busy;
    assign tx_done = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx                                                   |
// | Description : Self-checking bench for uart_tx with a frame-level model.    |
// |               Parity tests compile in when UART_TX_PARITY_EN is defined.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_tx;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_length = 1'b1;
    logic       tx_start = 1'b0;
`ifdef UART_TX_PARITY_EN
    logic       parity_odd = 1'b0;
`endif
    logic       tx;
    logic       busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
        .clk         (clk),
        .arst        (arst),
        .data_in     (data_in),
        .data_length (data_length),
`ifdef UART_TX_PARITY_EN
        .parity_odd  (parity_odd),
`endif
        .tx_start    (tx_start),
        .tx          (tx),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a list of bit levels, each lasting C clocks.
    logic m_busy = 1'b0;
    logic m_tx   = 1'b1;
    logic m_done = 1'b0;
    logic m_bits [0:10];
    int   m_pos  = 0;
    int   m_len  = 0;

    task automatic model_build();
        int  nb;
        int  k;
        logic p;
        nb = data_length ? 8 : 7;
        p  = 1'b0;
        m_bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            m_bits[1 + i] = data_in[i];
            p = p ^ data_in[i];
        end
        k = 1 + nb;
`ifdef UART_TX_PARITY_EN
        m_bits[k] = p ^ parity_odd;
        k++;
`endif
        m_bits[k] = 1'b1;
        m_len = (k + 1) * C;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge arst);
            if (arst) begin
                m_busy = 1'b0;
                m_done = 1'b0;
                m_tx   = 1'b1;
                m_pos  = 0;
            end else begin
                m_done = 1'b0;
                if (m_busy) begin
                    m_pos++;
                    if (m_pos == m_len) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end else if (tx_start) begin
                    model_build();
                    m_busy = 1'b1;
                    m_pos  = 0;
                end
                m_tx = m_busy ? m_bits[m_pos / C] : 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_tx", {31'd0, tx}, {31'd0, m_tx});
            chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
            chk("model_done", {31'd0, tx_done}, {31'd0, m_done});
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge (frame cycle 0).
    task automatic send(input logic [7:0] d, input logic len);
        data_in     = d;
        data_length = len;
        tx_start    = 1'b1;
        @(negedge clk);
        tx_start    = 1'b0;
    endtask

    task automatic capture(input int nbits, input int inj_at, input int hold_from,
                           output logic [15:0] seq, output int bcnt, output int dcnt);
        seq  = '0;
        bcnt = 0;
        dcnt = 0;
        for (int i = 0; i < nbits * C; i++) begin
            if (i == inj_at) begin
                tx_start = 1'b1;
                data_in  = 8'h00;
            end else if (i == inj_at + 1) begin
                tx_start = 1'b0;
            end
            if (i == hold_from) begin
                tx_start    = 1'b1;
                data_in     = 8'h3C;
                data_length = 1'b1;
            end
            if (i % C == 0) seq[i / C] = tx;
            if (busy) bcnt++;
            if (tx_done) dcnt++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || tx_done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, n < 200}, 32'd1);
        @(negedge clk);
    endtask

    logic [15:0] seq;
    int bcnt;
    int dcnt;

    initial begin
        // Reset held for 3 clocks
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        arst = 1'b0;
        repeat (2) @(negedge clk);

        // 0xA5, 8 data bits
        send(8'hA5, 1'b1);
        capture(10, -10, -10, seq, bcnt, dcnt);
        chk("a5_seq", {16'd0, seq}, 32'h34A);
        chk("a5_busy_cycles", bcnt, 32'd40);
        chk("a5_done_early", dcnt, 32'd0);
        chk("a5_done_end", {31'd0, tx_done}, 32'd1);
        chk("a5_busy_end", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("a5_done_single", {31'd0, tx_done}, 32'd0);
        @(negedge clk);

        // 0xFF, 7 data bits: bit 7 never appears
        send(8'hFF, 1'b0);
        capture(9, -10, -10, seq, bcnt, dcnt);
        chk("ff7_seq", {16'd0, seq}, 32'h1FE);
        chk("ff7_busy_cycles", bcnt, 32'd36);
        chk("ff7_tx_after", {31'd0, tx}, 32'd1);
        chk("ff7_done_end", {31'd0, tx_done}, 32'd1);
        @(negedge clk);

        // Ignored mid-frame start, then held start for a back-to-back frame
        send(8'hA5, 1'b1);
        capture(10, 13, 30, seq, bcnt, dcnt);
        chk("b2b_seq", {16'd0, seq}, 32'h34A);
        chk("b2b_busy_cycles", bcnt, 32'd40);
        chk("b2b_done_end", {31'd0, tx_done}, 32'd1);
        @(negedge clk);
        chk("b2b_next_start_tx", {31'd0, tx}, 32'd0);
        chk("b2b_next_start_busy", {31'd0, busy}, 32'd1);
        tx_start = 1'b0;
        wait_idle();

        // Reset during data bit 3 of 0x3C, applied between edges
        send(8'h3C, 1'b1);
        repeat (17) @(negedge clk);
        #2 arst = 1'b1;
        #1;
        chk("arst_async_tx", {31'd0, tx}, 32'd1);
        chk("arst_async_busy", {31'd0, busy}, 32'd0);
        chk("arst_async_done", {31'd0, tx_done}, 32'd0);
        repeat (2) @(negedge clk);
        arst = 1'b0;
        repeat (45) @(negedge clk);
        chk("arst_still_idle", {31'd0, busy}, 32'd0);
        send(8'h3C, 1'b1);
        capture(10, -10, -10, seq, bcnt, dcnt);
        chk("3c_seq", {16'd0, seq}, 32'h278);
        chk("3c_done_end", {31'd0, tx_done}, 32'd1);
        @(negedge clk);

`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b0;
        send(8'hA5, 1'b1);
        capture(11, -10, -10, seq, bcnt, dcnt);
        chk("par_even_seq", {16'd0, seq}, 32'h54A);
        chk("par_even_busy", bcnt, 32'd44);
        @(negedge clk);
        parity_odd = 1'b1;
        send(8'hA5, 1'b1);
        capture(11, -10, -10, seq, bcnt, dcnt);
        chk("par_odd_seq", {16'd0, seq}, 32'h74A);
        @(negedge clk);
        parity_odd = 1'b0;
        send(8'h7F, 1'b0);
        capture(10, -10, -10, seq, bcnt, dcnt);
        chk("par_7f_seq", {16'd0, seq}, 32'h3FE);
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
